// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter: FSM encoding,
// requester IDs and the default data returned on a watchdog abort.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2,
        DONE      = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter_if.sv
// External data bus between the arbiter (master) and the top-level slave.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  bus_re;
    logic [DATA_W/8-1:0]   bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_ready;

    modport master (
        output bus_re, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_re, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/bus_arb_watchdog.sv
// Wait-state watchdog: cleared on grant, counts stalled cycles, saturates at
// TIMEOUT and fires in the stall cycle that brings the count to TIMEOUT.
module bus_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic fire
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FIRE = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count_en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // TIMEOUT == 0 leaves the counter parked at zero and never fires
    assign fire = (TIMEOUT > 0) && count_en && (cnt_q == CNT_FIRE);

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester (fetch / memory stage) arbiter for the single external bus.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is mem-over-fetch.
//
// state     | meaning
// IDLE      | no transaction; arbitrate pending requests
// GRANT_IF  | fetch read on the bus, waiting for bus_ready / watchdog
// GRANT_MEM | load/store on the bus (or null request), waiting likewise
// DONE      | ack pulse to the owner, strobes already dropped
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  mem_req,
    input  logic                  mem_re,
    input  logic [DATA_W/8-1:0]   mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    bus_arbiter_if.master         bus,
    output logic                  timeout_err
);
    localparam int BE_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    req_id_e             owner_q;
    logic                bus_re_q;
    logic [BE_W-1:0]     bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;
    logic                timeout_q;

    logic grant_if, grant_mem, finish;
    logic in_grant, null_xfer, pick_mem;
    logic wd_en, wd_fire;

`ifdef BUS_ARB_RR_EN
    req_id_e last_grant_q;

    assign pick_mem = mem_req && (!if_req || (last_grant_q == REQ_IF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ_IF;
        end else if (grant_mem) begin
            last_grant_q <= REQ_MEM;
        end else if (grant_if) begin
            last_grant_q <= REQ_IF;
        end
    end
`else
    assign pick_mem = mem_req;
`endif

    assign in_grant  = (state_q == GRANT_IF) || (state_q == GRANT_MEM);
    // a memory request with neither re nor we completes without touching the bus
    assign null_xfer = (state_q == GRANT_MEM) && !bus_re_q && (bus_we_q == '0);
    assign wd_en     = in_grant && !bus.bus_ready && !null_xfer;

    bus_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant_if || grant_mem),
        .count_en (wd_en),
        .fire     (wd_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_mem) begin
                    grant_mem = 1'b1;
                    state_d   = GRANT_MEM;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_MEM: begin
                if (bus.bus_ready || wd_fire || null_xfer) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= REQ_IF;
            bus_re_q    <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= finish && wd_fire;
            if (grant_mem) begin
                owner_q     <= REQ_MEM;
                bus_re_q    <= mem_re;
                bus_we_q    <= mem_we;
                bus_addr_q  <= mem_addr;
                bus_wdata_q <= mem_wdata;
            end else if (grant_if) begin
                owner_q     <= REQ_IF;
                bus_re_q    <= 1'b1;
                bus_we_q    <= '0;
                bus_addr_q  <= if_addr;
                bus_wdata_q <= '0;
            end else if (finish) begin
                bus_re_q <= 1'b0;
                bus_we_q <= '0;
                // not null, so either the slave answered or the watchdog aborted
                if (!null_xfer) begin
                    if (owner_q == REQ_IF) begin
                        if_rdata_q <= bus.bus_ready ? bus.bus_rdata : ERR_DATA;
                    end else begin
                        mem_rdata_q <= bus.bus_ready ? bus.bus_rdata : ERR_DATA;
                    end
                end
            end
        end
    end

    assign bus.bus_re    = bus_re_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign if_ack      = (state_q == DONE) && (owner_q == REQ_IF);
    assign mem_ack     = (state_q == DONE) && (owner_q == REQ_MEM);
    assign if_rdata    = if_rdata_q;
    assign mem_rdata   = mem_rdata_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table of single transactions plus
// contention, reset-abort and idle-ready sequences.
module tb_bus_arbiter;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_re = 1'b0;
    logic [3:0]  mem_we = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .mem_req     (mem_req),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus         (bus.master),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic        is_mem;
        logic        re;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        exp_re;
        logic [3:0]  exp_we;
        logic        exp_to;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        if_req    = !v.is_mem;
        mem_req   = v.is_mem;
        if_addr   = v.addr;
        mem_addr  = v.addr;
        mem_re    = v.re;
        mem_we    = v.we;
        mem_wdata = v.wdata;
        bus.bus_ready = 1'b0;
        tick();
        // requester-side changes after grant must not reach the bus
        if_addr   = 32'hFFFF_FFF0;
        mem_addr  = 32'hFFFF_FFF0;
        mem_wdata = 32'h0;
        mem_we    = 4'hF;
        mem_re    = 1'b1;
        if (!v.exp_re && v.exp_we == 4'h0) begin
            chk1("null_re", bus.bus_re, 1'b0);
            chk("null_we", 32'(bus.bus_we), 32'h0);
            chk1("null_early_ack", mem_ack, 1'b0);
            tick();
        end else begin
            n = v.exp_to ? TO : v.waits + 1;
            for (int w = 0; w < n; w++) begin
                chk1("strobe_re", bus.bus_re, v.exp_re);
                chk("strobe_we", 32'(bus.bus_we), 32'(v.exp_we));
                chk("strobe_addr", bus.bus_addr, v.addr);
                if (v.exp_we != 4'h0) chk("strobe_wdata", bus.bus_wdata, v.wdata);
                chk1("early_ack", if_ack | mem_ack, 1'b0);
                chk1("early_timeout", timeout_err, 1'b0);
                bus.bus_ready = !v.exp_to && (w == v.waits);
                bus.bus_rdata = bus.bus_ready ? v.rdata : ~v.rdata;
                tick();
            end
        end
        bus.bus_ready = 1'b0;
        bus.bus_rdata = 32'h5555_AAAA;
        chk1("done_if_ack", if_ack, !v.is_mem);
        chk1("done_mem_ack", mem_ack, v.is_mem);
        chk1("done_timeout", timeout_err, v.exp_to);
        chk1("done_re", bus.bus_re, 1'b0);
        chk("done_we", 32'(bus.bus_we), 32'h0);
        if (v.chk_rd) chk("done_rdata", v.is_mem ? mem_rdata : if_rdata, v.exp_rd);
        if_req  = 1'b0;
        mem_req = 1'b0;
        tick();
        chk1("after_ack", if_ack | mem_ack, 1'b0);
        chk1("after_timeout", timeout_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic exp_mem;
        //          mem re  we     addr          wdata         wt rdata         ere ewe    to chk exp_rd
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 0, 32'h0000_0013, 1'b1, 4'h0, 1'b0, 1'b1, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b0, 4'h3, 32'h0000_2000, 32'hAABB_CCDD, 3, 32'h0, 1'b0, 4'h3, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 4'h0, 32'h0000_3004, 32'h0, 1, 32'h1234_5678, 1'b1, 4'h0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h0000_3008, 32'h0, 10, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_300C, 32'h0, 0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 2, 32'h0050_0093, 1'b1, 4'h0, 1'b0, 1'b1, 32'h0050_0093};
        vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h0000_4000, 32'h0102_0304, 9, 32'h0, 1'b0, 4'hF, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0, 3, 32'hCAFE_F00D, 1'b1, 4'h0, 1'b0, 1'b1, 32'hCAFE_F00D};

        bus.bus_ready = 1'b0;
        bus.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_if_ack", if_ack, 1'b0);
        chk1("rst_mem_ack", mem_ack, 1'b0);
        chk1("rst_bus_re", bus.bus_re, 1'b0);
        chk("rst_bus_we", 32'(bus.bus_we), 32'h0);
        chk("rst_bus_addr", bus.bus_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk1("rst_timeout", timeout_err, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        chk("mem_rdata_hold", mem_rdata, 32'hDEAD_BEEF);

        // bus_ready outside a grant must not start or finish anything
        bus.bus_ready = 1'b1;
        tick();
        tick();
        chk1("idle_ready_re", bus.bus_re, 1'b0);
        chk1("idle_ready_ack", if_ack | mem_ack, 1'b0);

        // contention, mem releases after its ack
        if_req = 1'b1;  if_addr = 32'h200;
        mem_req = 1'b1; mem_re = 1'b1; mem_we = 4'h0; mem_addr = 32'h300;
        bus.bus_rdata = 32'h22;
        tick();
        chk("cont_first_addr", bus.bus_addr, 32'h300);
        chk1("cont_first_re", bus.bus_re, 1'b1);
        tick();
        chk1("cont_first_mem_ack", mem_ack, 1'b1);
        chk1("cont_first_if_ack", if_ack, 1'b0);
        chk("cont_first_rdata", mem_rdata, 32'h22);
        mem_req = 1'b0;
        bus.bus_rdata = 32'h33;
        tick();
        chk1("cont_gap_ack", if_ack | mem_ack, 1'b0);
        tick();
        chk("cont_second_addr", bus.bus_addr, 32'h200);
        tick();
        chk1("cont_second_if_ack", if_ack, 1'b1);
        chk1("cont_second_mem_ack", mem_ack, 1'b0);
        chk("cont_second_rdata", if_rdata, 32'h33);
        chk("cont_mem_rdata_hold", mem_rdata, 32'h22);

        // both held continuously: one transaction per 3 cycles
        mem_req = 1'b1;
        tick();
        for (int r = 0; r < 4; r++) begin
`ifdef BUS_ARB_RR_EN
            exp_mem = (r % 2 == 0);
`else
            exp_mem = 1'b1;
`endif
            tick();
            chk("held_grant_addr", bus.bus_addr, exp_mem ? 32'h300 : 32'h200);
            tick();
            chk1("held_mem_ack", mem_ack, exp_mem);
            chk1("held_if_ack", if_ack, !exp_mem);
            tick();
            chk1("held_gap_ack", if_ack | mem_ack, 1'b0);
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        bus.bus_ready = 1'b0;
        tick();

        // asynchronous reset during a store
        mem_req = 1'b1; mem_re = 1'b0; mem_we = 4'hF;
        mem_addr = 32'h5000; mem_wdata = 32'h1234;
        tick();
        chk("rmid_we_before", 32'(bus.bus_we), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_we", 32'(bus.bus_we), 32'h0);
        chk("rmid_addr", bus.bus_addr, 32'h0);
        chk1("rmid_mem_ack", mem_ack, 1'b0);
        chk("rmid_if_rdata", if_rdata, 32'h0);
        chk("rmid_mem_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        mem_we = 4'h0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("rmid_no_ack", if_ack | mem_ack, 1'b0);
            chk1("rmid_no_re", bus.bus_re, 1'b0);
        end
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
